// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC fetch unit: branch-kind encoding and reset PC.
package npc_pkg;

    typedef enum logic [2:0] {
        BK_NONE = 3'd0,
        BK_BEQ  = 3'd1,
        BK_J    = 3'd2,
        BK_JAL  = 3'd3,
        BK_JR   = 3'd4
    } branch_kind_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_fetch_unit_if.sv
// Decoder/fetch-side bus of the next-PC unit; master drives D-stage info, slave is the unit.
interface npc_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    import npc_pkg::*;

    logic              stall;
    logic              d_valid;
    logic [2:0]        d_kind;
    logic [ADDR_W-1:0] d_pc;
    logic              d_equal;
    logic [15:0]       d_offset;
    logic [25:0]       d_index;
    logic [ADDR_W-1:0] d_jr_target;
    logic              d_jr_is_ra;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic              redirect;
    logic [ADDR_W-1:0] npc;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_mispredict;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output stall, d_valid, d_kind, d_pc, d_equal, d_offset, d_index,
               d_jr_target, d_jr_is_ra,
        input  pc, pc4, redirect, npc, ras_empty, ras_full, ras_mispredict,
               taken_count
    );

    modport slave (
        input  stall, d_valid, d_kind, d_pc, d_equal, d_offset, d_index,
               d_jr_target, d_jr_is_ra,
        output pc, pc4, redirect, npc, ras_empty, ras_full, ras_mispredict,
               taken_count
    );

endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; when full, a push silently overwrites the oldest entry.
module npc_ras
    import npc_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CW    = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CW-1:0]     r_count;
    logic [PTR_W-1:0]  w_top_idx;

    // r_ptr names the next free slot, so the newest entry sits one below it.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (pop && !empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: a zero count already marks every slot as stale.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            r_mem[r_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/npc_fetch_unit.sv
// Fetch PC register with delay-slot branch redirect, check-only RAS and taken-redirect counter.
module npc_fetch_unit
    import npc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 16
) (
    input logic              clk,
    input logic              reset,
    npc_fetch_unit_if.slave  bus
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_taken_count;
    logic              r_ras_mispredict;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_beq_target;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_target;
    logic              w_take;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_npc;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;

    // Target selection; undefined kinds fall to the default arm and never redirect.
    always_comb begin
        w_seq           = bus.d_pc + ADDR_W'(4);
        w_beq_target    = w_seq + {{(ADDR_W-18){bus.d_offset[15]}}, bus.d_offset, 2'b00};
        w_j_target      = w_seq;
        w_j_target[27:0] = {bus.d_index, 2'b00};
        w_target        = w_seq;
        w_take          = 1'b0;
        case (bus.d_kind)
            BK_BEQ: begin
                w_target = w_beq_target;
                w_take   = bus.d_equal;
            end
            BK_J, BK_JAL: begin
                w_target = w_j_target;
                w_take   = 1'b1;
            end
            BK_JR: begin
                w_target = bus.d_jr_target;
                w_take   = 1'b1;
            end
            default: begin
                w_target = w_seq;
                w_take   = 1'b0;
            end
        endcase
        w_redirect = bus.d_valid & w_take;
        w_pc4      = r_pc + ADDR_W'(4);
        w_npc      = w_redirect ? w_target : w_pc4;
    end

    assign w_push = !bus.stall && bus.d_valid && (bus.d_kind == BK_JAL);
    assign w_pop  = !bus.stall && bus.d_valid && (bus.d_kind == BK_JR) && bus.d_jr_is_ra;

    npc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (bus.d_pc + ADDR_W'(8)),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    // The slot is already in F while its branch is in D, so loading the target never needs a flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc             <= PC_INIT;
            r_taken_count    <= '0;
            r_ras_mispredict <= 1'b0;
        end else begin
            r_ras_mispredict <= w_pop && !w_ras_empty && (w_ras_top != bus.d_jr_target);
            if (!bus.stall) begin
                r_pc <= w_npc;
                if (w_redirect) begin
                    r_taken_count <= r_taken_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pc             = r_pc;
    assign bus.pc4            = w_pc4;
    assign bus.redirect       = w_redirect;
    assign bus.npc            = w_npc;
    assign bus.ras_empty      = w_ras_empty;
    assign bus.ras_full       = w_ras_full;
    assign bus.ras_mispredict = r_ras_mispredict;
    assign bus.taken_count    = r_taken_count;

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Directed, table-driven bench for npc_fetch_unit with hand-computed expectations.
module tb_npc_fetch_unit;
    import npc_pkg::*;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [2:0]  kind;
        logic [31:0] dpc;
        logic        eq;
        logic [15:0] off;
        logic [25:0] idx;
        logic [31:0] jrt;
        logic        ra;
        logic        expRed;
        logic [31:0] expNpc;
        logic [31:0] expPc;
        logic [15:0] expCnt;
        logic        expMis;
        logic        expEmpty;
        logic        expFull;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [31:0] curPc;
    vec_t vecs [17];
    vec_t v;

    npc_fetch_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    npc_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_3000),
        .RAS_DEPTH (4),
        .CNT_W     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t s);
        bus.stall       = s.stall;
        bus.d_valid     = s.valid;
        bus.d_kind      = s.kind;
        bus.d_pc        = s.dpc;
        bus.d_equal     = s.eq;
        bus.d_offset    = s.off;
        bus.d_index     = s.idx;
        bus.d_jr_target = s.jrt;
        bus.d_jr_is_ra  = s.ra;
    endtask

    // One cycle: check combinational outputs before the edge, registered state after it.
    task automatic applyStimulus(input string tag, input vec_t s);
        driveInputs(s);
        #1;
        checkOutput({tag, " redirect"}, {31'b0, bus.redirect}, {31'b0, s.expRed});
        checkOutput({tag, " npc"}, bus.npc, s.expNpc);
        checkOutput({tag, " pc4"}, bus.pc4, curPc + 32'd4);
        @(posedge clk);
        #1;
        checkOutput({tag, " pc"}, bus.pc, s.expPc);
        checkOutput({tag, " taken_count"}, {16'b0, bus.taken_count}, {16'b0, s.expCnt});
        checkOutput({tag, " ras_mispredict"}, {31'b0, bus.ras_mispredict}, {31'b0, s.expMis});
        checkOutput({tag, " ras_empty"}, {31'b0, bus.ras_empty}, {31'b0, s.expEmpty});
        checkOutput({tag, " ras_full"}, {31'b0, bus.ras_full}, {31'b0, s.expFull});
        curPc = s.expPc;
    endtask

    initial begin
        vecs[0]  = '{0,0,BK_NONE,32'h0,0,16'h0,26'h0,32'h0,0, 0,32'h3004,32'h3004,16'd0,0,1,0};
        vecs[1]  = '{0,0,BK_NONE,32'h0,0,16'h0,26'h0,32'h0,0, 0,32'h3008,32'h3008,16'd0,0,1,0};
        vecs[2]  = '{0,0,BK_NONE,32'h0,0,16'h0,26'h0,32'h0,0, 0,32'h300C,32'h300C,16'd0,0,1,0};
        vecs[3]  = '{0,1,BK_BEQ,32'h3010,1,16'hFFFC,26'h0,32'h0,0, 1,32'h3004,32'h3004,16'd1,0,1,0};
        vecs[4]  = '{0,1,BK_BEQ,32'h3010,0,16'hFFFC,26'h0,32'h0,0, 0,32'h3008,32'h3008,16'd1,0,1,0};
        vecs[5]  = '{0,1,BK_JAL,32'h3020,0,16'h0,26'hC10,32'h0,0, 1,32'h3040,32'h3040,16'd2,0,0,0};
        vecs[6]  = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3028,1, 1,32'h3028,32'h3028,16'd3,0,1,0};
        vecs[7]  = '{0,1,BK_JAL,32'h3020,0,16'h0,26'hC10,32'h0,0, 1,32'h3040,32'h3040,16'd4,0,0,0};
        vecs[8]  = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3030,1, 1,32'h3030,32'h3030,16'd5,1,1,0};
        vecs[9]  = '{0,0,BK_NONE,32'h0,0,16'h0,26'h0,32'h0,0, 0,32'h3034,32'h3034,16'd5,0,1,0};
        vecs[10] = '{0,1,BK_JAL,32'h3100,0,16'h0,26'hC80,32'h0,0, 1,32'h3200,32'h3200,16'd6,0,0,0};
        vecs[11] = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h5001,0, 1,32'h5001,32'h5001,16'd7,0,0,0};
        vecs[12] = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3108,1, 1,32'h3108,32'h3108,16'd8,0,1,0};
        vecs[13] = '{0,1,3'd7,32'h3000,1,16'h0010,26'hC10,32'h4000,1, 0,32'h310C,32'h310C,16'd8,0,1,0};
        vecs[14] = '{0,0,BK_BEQ,32'h3110,1,16'h0010,26'h0,32'h0,0, 0,32'h3110,32'h3110,16'd8,0,1,0};
        vecs[15] = '{0,1,BK_BEQ,32'h3110,1,16'h0010,26'h0,32'h0,0, 1,32'h3154,32'h3154,16'd9,0,1,0};
        vecs[16] = '{0,1,BK_J,32'hF000_0000,0,16'h0,26'hABC,32'h0,0, 1,32'hF000_2AF0,32'hF000_2AF0,16'd10,0,1,0};

        reset = 1'b0;
        driveInputs(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pc", bus.pc, 32'h3000);
        checkOutput("reset taken_count", {16'b0, bus.taken_count}, 32'd0);
        checkOutput("reset ras_mispredict", {31'b0, bus.ras_mispredict}, 32'd0);
        checkOutput("reset ras_empty", {31'b0, bus.ras_empty}, 32'd1);
        checkOutput("reset ras_full", {31'b0, bus.ras_full}, 32'd0);
        reset = 1'b1;
        curPc = 32'h3000;

        for (int i = 0; i < 17; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Five JALs into a 4-deep RAS: the fifth overwrites the oldest return address 0x3008.
        for (int k = 0; k < 5; k++) begin
            v = '{0,1,BK_JAL,32'h3000 + 32'(16*k),0,16'h0,26'hC00,32'h0,0,
                  1,32'h3000,32'h3000,16'(11+k),0,0,(k >= 3)};
            applyStimulus($sformatf("fill%0d", k), v);
        end
        for (int k = 0; k < 5; k++) begin
            v = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3048 - 32'(16*k),1,
                  1,32'h3048 - 32'(16*k),32'h3048 - 32'(16*k),16'(16+k),0,(k >= 3),0};
            applyStimulus($sformatf("pop%0d", k), v);
        end

        // Stalled redirecting JR with a wrong RAS guess: nothing moves until the stall drops.
        v = '{0,1,BK_JAL,32'h3020,0,16'h0,26'hC10,32'h0,0, 1,32'h3040,32'h3040,16'd21,0,0,0};
        applyStimulus("stall_jal0", v);
        v = '{0,1,BK_JAL,32'h3040,0,16'h0,26'hC20,32'h0,0, 1,32'h3080,32'h3080,16'd22,0,0,0};
        applyStimulus("stall_jal1", v);
        for (int k = 0; k < 3; k++) begin
            v = '{1,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3044,1, 1,32'h3044,32'h3080,16'd22,0,0,0};
            applyStimulus($sformatf("stall%0d", k), v);
        end
        v = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3044,1, 1,32'h3044,32'h3044,16'd23,1,0,0};
        applyStimulus("unstall_jr", v);
        v = '{0,1,BK_JAL,32'h3100,0,16'h0,26'hC80,32'h0,0, 1,32'h3200,32'h3200,16'd24,0,0,0};
        applyStimulus("refill_jal", v);

        // Reset while stalled with two RAS entries present.
        reset = 1'b0;
        v = '{1,1,BK_JAL,32'h3300,0,16'h0,26'hC10,32'h0,0, 1,32'h3040,32'h3000,16'd0,0,1,0};
        driveInputs(v);
        @(posedge clk);
        #1;
        checkOutput("midreset pc", bus.pc, 32'h3000);
        checkOutput("midreset taken_count", {16'b0, bus.taken_count}, 32'd0);
        checkOutput("midreset ras_empty", {31'b0, bus.ras_empty}, 32'd1);
        checkOutput("midreset ras_full", {31'b0, bus.ras_full}, 32'd0);
        checkOutput("midreset ras_mispredict", {31'b0, bus.ras_mispredict}, 32'd0);
        reset = 1'b1;
        curPc = 32'h3000;
        v = '{0,1,BK_JR,32'h0,0,16'h0,26'h0,32'h3100,1, 1,32'h3100,32'h3100,16'd1,0,1,0};
        applyStimulus("post_reset_jr", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
